ram_sort_ctrl: RTL
==================

// Module: ram_sort_ctrl
// PURPOSE
//  In-place ascending bubble-sort sequencer for the 8x8 RAM. After `start` it owns the RAM bus (add/wr/data),
//  compares adjacent words and writes swapped pairs back, then pulses `done`. Sits between top-level control and RAM.
// PARAMETERS
//  DEPTH  8  number of RAM words sorted (indices 0..DEPTH-1)
//  AW     3  RAM address width, $clog2(DEPTH)
//  DW     8  RAM data width; compare is unsigned
//  SW     localparam $clog2(DEPTH*(DEPTH-1)/2+1) = 5, swap-counter width
// PORTS
//  clk        in     1   system clock, all state on rising edge
//  rst        in     1   synchronous, active-high reset
//  start      in     1   sort request, sampled in IDLE only
//  busy       out    1   high while a sort is in progress
//  done       out    1   one-cycle pulse on sort completion
//  swap_cnt   out    SW  swaps performed by the last/current sort
//  ram_add    out    AW  RAM address
//  ram_wr     out    1   RAM write strobe, active-low (1 = read, 0 = write on next edge)
//  ram_data   inout  DW  RAM data bus; driven only when ram_wr=0, else 'z
// BEHAVIOUR
//  - Reset: state IDLE, busy=0, done=0, swap_cnt=0, ram_add=0, ram_wr=1, ram_data='z; pass p=0, index j=0.
//  - States: IDLE, RD_A, RD_B, CMP, WR_A, WR_B, FIN.
//  - IDLE: start=1 -> RD_A; p=0, j=0, swap_cnt=0, pass_swapped=0. start=0 -> stay.
//  - RD_A: ram_add=j, ram_wr=1; reg_a<=ram_data at edge -> RD_B.
//  - RD_B: ram_add=j+1, ram_wr=1; reg_b<=ram_data -> CMP.
//  - CMP: no bus write (ram_wr=1). reg_a>reg_b -> WR_A; else (incl. equal) advance index.
//  - WR_A: ram_add=j, ram_wr=0, drive reg_b -> WR_B.
//  - WR_B: ram_add=j+1, ram_wr=0, drive reg_a; swap_cnt++, pass_swapped=1; then advance index.
//  - Advance: j<DEPTH-2-p -> j++, RD_A. Else end of pass:
//    p==DEPTH-2 -> FIN; otherwise p++, j=0, pass_swapped=0, RD_A.
//  - FIN: busy=0, done=1 for exactly this cycle -> IDLE. start in FIN is ignored.
//  - busy=1 in RD_A..WR_B. start while busy: ignored, no restart or queueing.
//  - Cost per compare: 3 cycles; +2 cycles per swap.
//  - done is high in cycle 3*C+2*S+1 after the accepting edge (C = compares, S = swaps).
//  - Full sort: C=DEPTH*(DEPTH-1)/2=28.
//  - Bus: ram_data is driven iff ram_wr=0. No cycle has both controller and RAM driving.
//  - swap_cnt holds its value after done until the next accepted start. Max value 28, no wrap.
//  - rst mid-sort: next edge forces the reset state, and the bus is released that cycle.
//    Reset between WR_A and WR_B can leave a duplicated word. The shared rst also reloads the RAM init image.
// CONFIGURATION
//  EARLY_EXIT_EN defined:
//    at end of a pass with pass_swapped=0 -> FIN immediately (sorted data early-out).
//  Undefined: all DEPTH-1 passes always run; C fixed at 28.
// STRUCTURE
//  - Shared header ram_sort_defs.vh: state encodings (3-bit localparams), DEPTH/AW/DW defaults, SW formula.
//  - Sub-module sort_idx_cnt: p/j counters, end-of-pass and last-pass flags.
//  - FSM, compare and tristate driver live in ram_sort_ctrl.
// TESTING (bench instantiates RAM + ram_sort_ctrl, rst=1 then 0; RAM init 90,25,60,15,30,75,45,10)
//  1. start 1 cycle -> busy next cycle; done at cycle 121 (28*3+18*2+1); swap_cnt=18.
//     RAM reads 10,15,25,30,45,60,75,90.
//  2. Re-start on sorted RAM -> no write cycles (ram_wr stays 1), swap_cnt=0.
//     done at 85 without EARLY_EXIT_EN; at 22 with it (7 compares).
//  3. Duplicates: preload 5,5,5,5,5,5,5,5 -> zero swaps, no writes, contents unchanged.
//  4. start pulsed repeatedly while busy -> single sort, same timing and result as test 1; start in FIN cycle ignored.
//  5. rst asserted on cycle 40 of a sort -> next cycle busy=0, ram_wr=1, ram_data='z, swap_cnt=0.
//     RAM back to init; fresh start gives test-1 result.
//  6. Bus checker on every cycle: ram_data never 'x; controller drives only when ram_wr=0.

Source files
------------

// File: rtl/ram_sort_ctrl_pkg.sv
// Shared definitions for the RAM bubble-sort sequencer.
// Contents: default geometry (depth, address and data widths), the FSM state
// encoding, and a helper that sizes the swap counter from the depth.
package ram_sort_ctrl_pkg;

  localparam int RS_DEPTH = 8;
  localparam int RS_AW    = $clog2(RS_DEPTH);
  localparam int RS_DW    = 8;

  // Swap counter must hold the worst case: every compare of a full sort swaps.
  function automatic int sw_width(input int depth);
    return $clog2(depth * (depth - 1) / 2 + 1);
  endfunction

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CMP  = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    FIN  = 3'd6
  } state_t;

endpackage

// File: rtl/ram_sort_ctrl_idx_cnt.sv
// Pass / index counters for the bubble sort.
// Ports: clk, rst (sync, active-high); clear restarts at pass 0 index 0;
//   step advances the index (or moves to the next pass); j, end_of_pass, last_pass out.
module ram_sort_ctrl_idx_cnt #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [AW-1:0] j,
  output logic          end_of_pass,
  output logic          last_pass
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 2);

  logic [AW-1:0] p;

  // Pass p compares pairs j = 0 .. DEPTH-2-p; the tail is already in place.
  assign end_of_pass = (j == LAST_IDX - p);
  assign last_pass   = (p == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      j <= '0;
    end else if (clear) begin
      p <= '0;
      j <= '0;
    end else if (step) begin
      if (!end_of_pass) begin
        j <= j + AW'(1);
      end else if (!last_pass) begin
        p <= p + AW'(1);
        j <= '0;
      end
    end
  end

endmodule

// File: rtl/ram_sort_ctrl.sv
// In-place ascending bubble sort of an external RAM over a shared tristate bus.
// Ports: clk, rst (sync, active-high), start in; busy, done (1-cycle pulse), swap_cnt out;
//   ram_add, ram_wr (active-low write strobe), ram_data (driven only while ram_wr=0).
// Optional: define EARLY_EXIT_EN to stop after the first pass that performs no swap.
module ram_sort_ctrl
  import ram_sort_ctrl_pkg::*;
#(
  parameter  int DEPTH = RS_DEPTH,
  parameter  int AW    = RS_AW,
  parameter  int DW    = RS_DW,
  localparam int SW    = sw_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] swap_cnt,
  output logic [AW-1:0] ram_add,
  output logic          ram_wr,
  inout  wire  [DW-1:0] ram_data
);

  state_t        state;
  logic [DW-1:0] reg_a;
  logic [DW-1:0] reg_b;
  logic [DW-1:0] wr_dat;

  logic [AW-1:0] j;
  logic [AW-1:0] j_nxt;
  logic          end_of_pass;
  logic          last_pass;
  logic          accept;
  logic          a_gt_b;
  logic          step;
  logic          early_out;
  logic          finish;

  assign accept = (state == IDLE) && start;
  assign a_gt_b = (reg_a > reg_b);
  assign j_nxt  = j + AW'(1);

  // A compare finishes either in CMP (no swap) or after the second write.
  assign step   = ((state == CMP) && !a_gt_b) || (state == WR_B);

  ram_sort_ctrl_idx_cnt #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_idx_cnt (
    .clk         (clk),
    .rst         (rst),
    .clear       (accept),
    .step        (step),
    .j           (j),
    .end_of_pass (end_of_pass),
    .last_pass   (last_pass)
  );

`ifdef EARLY_EXIT_EN
  logic pass_swapped;

  // A swap finishing in this very cycle (WR_B) must count for the current pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_swapped <= 1'b0;
    end else if (accept) begin
      pass_swapped <= 1'b0;
    end else if (step) begin
      pass_swapped <= end_of_pass ? 1'b0 : (pass_swapped || (state == WR_B));
    end
  end

  assign early_out = !(pass_swapped || (state == WR_B));
`else
  assign early_out = 1'b0;
`endif

  assign finish = end_of_pass && (last_pass || early_out);

  // Controller drives the bus only in write cycles; the RAM drives it otherwise.
  assign ram_data = ram_wr ? {DW{1'bz}} : wr_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      swap_cnt <= '0;
      ram_add  <= '0;
      ram_wr   <= 1'b1;
      wr_dat   <= '0;
      reg_a    <= '0;
      reg_b    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD_A;
            busy     <= 1'b1;
            swap_cnt <= '0;
            ram_add  <= '0;
            ram_wr   <= 1'b1;
          end
        end
        RD_A: begin
          reg_a   <= ram_data;
          ram_add <= j_nxt;
          state   <= RD_B;
        end
        RD_B: begin
          reg_b <= ram_data;
          state <= CMP;
        end
        CMP: begin
          if (a_gt_b) begin
            state   <= WR_A;
            ram_add <= j;
            ram_wr  <= 1'b0;
            wr_dat  <= reg_b;
          end
        end
        WR_A: begin
          state   <= WR_B;
          ram_add <= j_nxt;
          wr_dat  <= reg_a;
        end
        WR_B: begin
          swap_cnt <= swap_cnt + SW'(1);
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Index advance shared by the no-swap compare and the end of a swap.
      if (step) begin
        ram_wr <= 1'b1;
        if (finish) begin
          state   <= FIN;
          busy    <= 1'b0;
          done    <= 1'b1;
          ram_add <= '0;
        end else begin
          state   <= RD_A;
          ram_add <= end_of_pass ? '0 : j_nxt;
        end
      end
    end
  end

endmodule
